// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are streamed LSB-first through one
// full-adder cell, with a carry flop closing the loop between bits.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Handshake: sa_start is a level request sampled only in IDLE (no queueing);
// sa_done is a one-cycle pulse with no backpressure, results held until the next one.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             sa_clk,
    input  logic             sa_rst,
    input  logic             sa_start,
    input  logic [WIDTH-1:0] sa_port_a,
    input  logic [WIDTH-1:0] sa_port_b,
    input  logic             sa_cin,
    output logic             sa_busy,
    output logic             sa_done,
    output logic [WIDTH-1:0] sa_sum,
    output logic             sa_cout,
    output logic             sa_ovf,
    output logic [1:0]       sa_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] reg_a, reg_b, reg_s;
    logic [WIDTH-1:0] s_next;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             fa_sum, fa_cout;
    logic             last;

    serial_adder_fa fa (
        .a    (reg_a[0]),
        .b    (reg_b[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last   = (state_q == SHIFT) && (cnt == LAST);
    assign s_next = {fa_sum, reg_s[WIDTH-1:1]};

    always_ff @(posedge sa_clk or posedge sa_rst) begin
        if (sa_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sa_start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sa_clk or posedge sa_rst) begin
        if (sa_rst) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_s   <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sa_sum  <= '0;
            sa_cout <= 1'b0;
            sa_ovf  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sa_start) begin
                        reg_a <= sa_port_a;
                        reg_b <= sa_port_b;
                        c     <= sa_cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    reg_s <= s_next;
                    reg_a <= reg_a >> 1;
                    reg_b <= reg_b >> 1;
                    c     <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // On the MSB, c still holds the carry into the sign bit.
                    if (last) begin
                        sa_sum  <= s_next;
                        sa_cout <= fa_cout;
                        sa_ovf  <= fa_cout ^ c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sa_busy      = (state_q == SHIFT);
    assign sa_done      = (state_q == DONE);
    assign sa_dbg_state = state_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder. It captures two operands and a carry-in on a start request, then streams them LSB-first through the team's single 1-bit full-adder cell (FA), one bit per clock. A registered carry flip-flop closes the loop between bits. The block sits directly upstream of FA, sequences its inputs and collects its sum/carry outputs into a result register. It replaces a WIDTH-wide ripple chain when area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.

- sa_clk  input  1  system clock; all state updates on the rising edge.
- sa_rst  input  1  asynchronous, active-high reset.
- sa_start  input  1  request to begin an addition; sampled only in IDLE.
- sa_port_a  input  WIDTH  operand A, captured when the start request is accepted.
- sa_port_b  input  WIDTH  operand B, captured when the start request is accepted.
- sa_cin  input  1  carry-in, captured when the start request is accepted.
- sa_busy  output  1  high while an addition is in progress (SHIFT state).
- sa_done  output  1  one-cycle pulse; result outputs are valid.
- sa_sum  output  WIDTH  registered sum, held until the next completion.
- sa_cout  output  1  registered carry out of the MSB.
- sa_ovf  output  1  registered two's-complement overflow flag.

## Operation
- Internal state:
  - shift registers reg_a and reg_b (WIDTH bits each)
  - carry flip-flop c
  - sum shift register reg_s
  - bit counter cnt, width ceil(log2(WIDTH+1))
  - previous-carry bit c_msb
- FSM states: IDLE, SHIFT, DONE.
- IDLE with sa_start=1:
  - reg_a <= sa_port_a, reg_b <= sa_port_b, c <= sa_cin, cnt <= 0.
  - Go to SHIFT.
- SHIFT, each cycle:
  - FA inputs: a = reg_a[0], b = reg_b[0], cin = c.
  - reg_s <= {fa_sum, reg_s[WIDTH-1:1]}.
  - reg_a and reg_b shift right one bit; c <= fa_cout.
  - When cnt == WIDTH-1, latch c_msb <= c, which is the carry into the MSB.
  - cnt <= cnt+1.
  - After the edge on which cnt == WIDTH-1, go to DONE.
- SHIFT to DONE edge:
  - sa_sum <= final reg_s value, which includes the MSB sum bit.
  - sa_cout <= fa_cout.
  - sa_ovf <= fa_cout XOR c.
- DONE: sa_done=1 for exactly this one cycle; unconditionally return to IDLE.
- Arithmetic: {sa_cout, sa_sum} = sa_port_a + sa_port_b + sa_cin, modulo 2^(WIDTH+1).
- sa_ovf = 1 iff A and B have the same sign bit and sa_sum's sign bit differs from it.
- sa_start in SHIFT or DONE is ignored and not queued. Operand inputs may change freely after acceptance.
- sa_start held high continuously starts a new addition on every IDLE visit.
- Reset, at power-up or mid-operation:
  - state <= IDLE.
  - All registers are cleared: sa_sum=0, sa_cout=0, sa_ovf=0, sa_busy=0, sa_done=0.
  - The interrupted addition is discarded and produces no done pulse.

## Timing
- Start accepted on rising edge k (state IDLE, sa_start=1).
- sa_busy is high from after edge k through edge k+WIDTH, i.e. for WIDTH cycles.
- Bit i is processed on edge k+1+i.
- sa_sum, sa_cout and sa_ovf update on edge k+WIDTH; sa_done is high from edge k+WIDTH to edge k+WIDTH+1.
- The earliest next acceptance is edge k+WIDTH+2, so throughput is one addition per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Result outputs never change except on the completion edge or on reset.

## Test plan
- WIDTH=8, A=0x5A, B=0x33, cin=0 -> after WIDTH+1 cycles:
  - done pulse; sum=0x8D, cout=0, ovf=1.
- A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- A=0x80, B=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- A=0x00, B=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
  - Previous result held unchanged until this done edge.
- Start pulse repeated at cycles 2 and 5 of SHIFT with different operands -> ignored.
  - Result matches the first operands; exactly one done pulse.
- Reset asserted asynchronously at SHIFT cycle 3 -> outputs 0 immediately, no done.
  - A start after release (A=0x10, B=0x20) gives sum=0x30 after WIDTH+1 cycles.
  - With sa_start held high, done pulses recur every WIDTH+2 cycles.
